// File: rtl/hamming_secded_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_decoder_pipe
// Brief    : Two-stage extended-Hamming SECDED decoder/corrector with
//            valid/ready streaming and saturating error counters.
// Revision : 1.0
// ============================================================================
module hamming_secded_decoder_pipe #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    // Closed form of the smallest R with 2**R >= DATA_W+R+1
    localparam int R      = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int N      = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_cw,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // Codeword position of data bit j: the j-th non-power-of-two position
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              w_advance;
    logic [R-1:0]      w_syn;
    logic              w_ov;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_data;
    logic              w_syn_nz;
    logic              w_in_range;
    logic              w_single;
    logic              w_double;
    logic              w_flip;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [R-1:0]      r_s1_syn;
    logic              r_s1_ov;
    logic              r_s1_cen;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [R-1:0]      r_out_syn;
    logic              r_err_single;
    logic              r_err_double;
    logic [CNT_W-1:0]  r_cnt_single;
    logic [CNT_W-1:0]  r_cnt_double;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance && !rst;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i < N; i++) begin
            if (in_cw[i]) w_syn = w_syn ^ R'(i);
        end
    end

    assign w_ov = ^in_cw;

    assign w_syn_nz = |r_s1_syn;

    // Syndromes above N-1 only exist when the code is shortened
    if (N == (1 << R)) begin : g_full_code
        assign w_in_range = 1'b1;
    end else begin : g_short_code
        assign w_in_range = (r_s1_syn <= R'(N - 1));
    end

    assign w_single = r_s1_ov && (!w_syn_nz || w_in_range);
    assign w_double = w_syn_nz && (!r_s1_ov || !w_in_range);
    assign w_flip   = r_s1_cen && r_s1_ov && w_syn_nz && w_in_range;

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int c_pos = data_pos(j);
        assign w_raw[j]  = in_cw[c_pos];
        assign w_data[j] = r_s1_data[j] ^ (w_flip && (r_s1_syn == R'(c_pos)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_syn     <= '0;
            r_s1_ov      <= 1'b0;
            r_s1_cen     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_syn    <= '0;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_out_valid <= r_s1_valid;
            if (in_valid) begin
                r_s1_data <= w_raw;
                r_s1_syn  <= w_syn;
                r_s1_ov   <= w_ov;
                r_s1_cen  <= correct_en;
            end
            if (r_s1_valid) begin
                r_out_data   <= w_data;
                r_out_syn    <= r_s1_syn;
                r_err_single <= w_single;
                r_err_double <= w_double;
            end
        end
    end

    // Counting on the handshake means a stalled word is seen only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_err_single && (r_cnt_single != '1)) r_cnt_single <= r_cnt_single + CNT_W'(1);
            if (r_err_double && (r_cnt_double != '1)) r_cnt_double <= r_cnt_double + CNT_W'(1);
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_syndrome   = r_out_syn;
    assign out_err_single = r_err_single;
    assign out_err_double = r_err_double;
    assign cnt_single     = r_cnt_single;
    assign cnt_double     = r_cnt_double;

endmodule
`default_nettype wire
